multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 73 +++++++
 rtl/multicycle_control_decode.sv | 84 ++++++++
 rtl/multicycle_control.sv | 94 +++++++++
 tb/tb_multicycle_control.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - opcodes, ALU codes, state encoding and control word for the multicycle controller
package multicycle_control_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_SHIFT = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_cond_eq;
    logic       pc_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
    logic       illegal;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  // ALU operation for the I-type execute step, captured while in DECODE
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// rtl/multicycle_control_decode.sv - combinational state/opcode to control word table
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  input  logic [2:0] imm_op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SHIFT;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.pc_cond_eq = (op == OP_BEQ);
        ctrl.pc_cond_ne = (op == OP_BNE);
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_op;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_TRAP: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM: state register, reset gating and output mapping
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_W       = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCondEQ,
  output logic               PCWriteCondNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               InstrDone,
  output logic               Illegal,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         State
);

  state_t     state;
  logic [2:0] imm_op_q;
  logic       mem_ready;
  ctrl_t      ctrl;

  assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      imm_op_q <= 3'b000;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          imm_op_q <= imm_aluop(OP);
          case (OP)
            OP_LW, OP_SW:             state <= S_MEM_ADDR;
            OP_R:                     state <= S_R_EXEC;
            OP_BEQ, OP_BNE:           state <= S_BRANCH;
            OP_J:                     state <= S_JUMP;
            OP_ADDI, OP_ORI, OP_LUI:  state <= S_I_EXEC;
            default:                  state <= S_TRAP;
          endcase
        end
        S_MEM_ADDR: state <= (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_R_EXEC:   state <= S_R_WB;
        S_I_EXEC:   state <= S_I_WB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  multicycle_control_decode u_decode (
    .state     (state),
    .op        (OP),
    .mem_ready (mem_ready),
    .imm_op    (imm_op_q),
    .ctrl      (ctrl)
  );

  // Write strobes are masked during reset so an abandoned instruction never commits
  assign PCWrite       = ctrl.pc_write   & ~reset;
  assign PCWriteCondEQ = ctrl.pc_cond_eq & ~reset;
  assign PCWriteCondNE = ctrl.pc_cond_ne & ~reset;
  assign IRWrite       = ctrl.ir_write   & ~reset;
  assign MemWrite      = ctrl.mem_write  & ~reset;
  assign RegWrite      = ctrl.reg_write  & ~reset;
  assign InstrDone     = ctrl.instr_done & ~reset;
  assign IorD          = ctrl.iord;
  assign MemRead       = ctrl.mem_read;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign RegDst        = ctrl.reg_dst;
  assign Illegal       = ctrl.illegal;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign PCSource      = ctrl.pc_source;
  assign ALUOp         = ALUOP_W'(ctrl.alu_op);
  assign State         = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic       MemReady;
  logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, InstrDone, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(3), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .InstrDone(InstrDone), .Illegal(Illegal), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .State(State)
  );

  // Expected word: {State, PCW, CEQ, CNE, IorD, MRd, MWr, M2R, IRW, SrcA, RegW, RegDst, Done, Ill, SrcB, PCSrc, ALUOp}
  //                                    P C C I M M M I S R R D I
  localparam logic [23:0] E_FETCH_RDY  = {4'd0,  13'b1_0_0_0_1_0_0_1_0_0_0_0_0, 2'd1, 2'd0, 3'b100};
  localparam logic [23:0] E_FETCH_WAIT = {4'd0,  13'b0_0_0_0_1_0_0_0_0_0_0_0_0, 2'd1, 2'd0, 3'b100};
  localparam logic [23:0] E_DECODE     = {4'd1,  13'b0_0_0_0_0_0_0_0_0_0_0_0_0, 2'd3, 2'd0, 3'b100};
  localparam logic [23:0] E_MEM_ADDR   = {4'd2,  13'b0_0_0_0_0_0_0_0_1_0_0_0_0, 2'd2, 2'd0, 3'b100};
  localparam logic [23:0] E_MEM_RD     = {4'd3,  13'b0_0_0_1_1_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 3'b000};
  localparam logic [23:0] E_MEM_WB     = {4'd4,  13'b0_0_0_0_0_0_1_0_0_1_0_1_0, 2'd0, 2'd0, 3'b000};
  localparam logic [23:0] E_MEM_WR_RDY = {4'd5,  13'b0_0_0_1_0_1_0_0_0_0_0_1_0, 2'd0, 2'd0, 3'b000};
  localparam logic [23:0] E_MEM_WR_WT  = {4'd5,  13'b0_0_0_1_0_1_0_0_0_0_0_0_0, 2'd0, 2'd0, 3'b000};
  localparam logic [23:0] E_MEM_WR_RST = {4'd5,  13'b0_0_0_1_0_0_0_0_0_0_0_0_0, 2'd0, 2'd0, 3'b000};
  localparam logic [23:0] E_R_EXEC     = {4'd6,  13'b0_0_0_0_0_0_0_0_1_0_0_0_0, 2'd0, 2'd0, 3'b111};
  localparam logic [23:0] E_R_WB       = {4'd7,  13'b0_0_0_0_0_0_0_0_0_1_1_1_0, 2'd0, 2'd0, 3'b000};
  localparam logic [23:0] E_BRANCH_NE  = {4'd8,  13'b0_0_1_0_0_0_0_0_1_0_0_1_0, 2'd0, 2'd1, 3'b001};
  localparam logic [23:0] E_BRANCH_EQ  = {4'd8,  13'b0_1_0_0_0_0_0_0_1_0_0_1_0, 2'd0, 2'd1, 3'b001};
  localparam logic [23:0] E_JUMP       = {4'd9,  13'b1_0_0_0_0_0_0_0_0_0_0_1_0, 2'd0, 2'd2, 3'b000};
  localparam logic [23:0] E_I_EXEC_LUI = {4'd10, 13'b0_0_0_0_0_0_0_0_1_0_0_0_0, 2'd2, 2'd0, 3'b011};
  localparam logic [23:0] E_I_EXEC_ORI = {4'd10, 13'b0_0_0_0_0_0_0_0_1_0_0_0_0, 2'd2, 2'd0, 3'b101};
  localparam logic [23:0] E_I_WB       = {4'd11, 13'b0_0_0_0_0_0_0_0_0_1_0_1_0, 2'd0, 2'd0, 3'b000};
  localparam logic [23:0] E_TRAP       = {4'd12, 13'b0_0_0_0_0_0_0_0_0_0_0_0_1, 2'd0, 2'd0, 3'b000};

  // Apply inputs mid-cycle, check the settled outputs, then advance past the next rising edge
  task automatic step(input logic rdy, input logic [5:0] op, input logic rst,
                      input string tag, input logic [23:0] exp);
    logic [23:0] obs;
    MemReady = rdy;
    OP       = op;
    reset    = rst;
    #1;
    obs = {State, PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, ALUSrcA, RegWrite, RegDst, InstrDone, Illegal, ALUSrcB, PCSource, ALUOp};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset    = 1'b1;
    MemReady = 1'b1;
    OP       = 6'h00;
    @(posedge clk);
    #2;
    step(1'b1, 6'h00, 1'b1, "reset_fetch_gated", E_FETCH_WAIT);

    // R-type: 0,1,6,7,0
    step(1'b1, 6'h00, 1'b0, "r_fetch",  E_FETCH_RDY);
    step(1'b1, 6'h00, 1'b0, "r_decode", E_DECODE);
    step(1'b1, 6'h00, 1'b0, "r_exec",   E_R_EXEC);
    step(1'b1, 6'h00, 1'b0, "r_wb",     E_R_WB);

    // LW with two wait cycles in MEM_RD: 0,1,2,3,3,3,4,0
    step(1'b1, 6'h23, 1'b0, "lw_fetch",   E_FETCH_RDY);
    step(1'b1, 6'h23, 1'b0, "lw_decode",  E_DECODE);
    step(1'b1, 6'h23, 1'b0, "lw_addr",    E_MEM_ADDR);
    step(1'b0, 6'h23, 1'b0, "lw_rd_wt0",  E_MEM_RD);
    step(1'b0, 6'h23, 1'b0, "lw_rd_wt1",  E_MEM_RD);
    step(1'b1, 6'h23, 1'b0, "lw_rd_rdy",  E_MEM_RD);
    step(1'b1, 6'h23, 1'b0, "lw_wb",      E_MEM_WB);

    // SW with three FETCH wait cycles
    step(1'b0, 6'h2B, 1'b0, "sw_fetch_wt0", E_FETCH_WAIT);
    step(1'b0, 6'h2B, 1'b0, "sw_fetch_wt1", E_FETCH_WAIT);
    step(1'b0, 6'h2B, 1'b0, "sw_fetch_wt2", E_FETCH_WAIT);
    step(1'b1, 6'h2B, 1'b0, "sw_fetch",     E_FETCH_RDY);
    step(1'b1, 6'h2B, 1'b0, "sw_decode",    E_DECODE);
    step(1'b1, 6'h2B, 1'b0, "sw_addr",      E_MEM_ADDR);
    step(1'b1, 6'h2B, 1'b0, "sw_wr",        E_MEM_WR_RDY);

    // BNE and BEQ
    step(1'b1, 6'h05, 1'b0, "bne_fetch",  E_FETCH_RDY);
    step(1'b1, 6'h05, 1'b0, "bne_decode", E_DECODE);
    step(1'b1, 6'h05, 1'b0, "bne_branch", E_BRANCH_NE);
    step(1'b1, 6'h04, 1'b0, "beq_fetch",  E_FETCH_RDY);
    step(1'b1, 6'h04, 1'b0, "beq_decode", E_DECODE);
    step(1'b1, 6'h04, 1'b0, "beq_branch", E_BRANCH_EQ);

    // LUI: OP changes during I_EXEC must not disturb the captured ALUOp
    step(1'b1, 6'h0F, 1'b0, "lui_fetch",  E_FETCH_RDY);
    step(1'b1, 6'h0F, 1'b0, "lui_decode", E_DECODE);
    step(1'b1, 6'h0D, 1'b0, "lui_exec",   E_I_EXEC_LUI);
    step(1'b1, 6'h0D, 1'b0, "lui_wb",     E_I_WB);

    // ORI and J
    step(1'b1, 6'h0D, 1'b0, "ori_fetch",  E_FETCH_RDY);
    step(1'b1, 6'h0D, 1'b0, "ori_decode", E_DECODE);
    step(1'b1, 6'h0D, 1'b0, "ori_exec",   E_I_EXEC_ORI);
    step(1'b1, 6'h0D, 1'b0, "ori_wb",     E_I_WB);
    step(1'b1, 6'h02, 1'b0, "j_fetch",    E_FETCH_RDY);
    step(1'b1, 6'h02, 1'b0, "j_decode",   E_DECODE);
    step(1'b1, 6'h02, 1'b0, "j_jump",     E_JUMP);

    // Reset during a MEM_WR wait abandons the store
    step(1'b1, 6'h2B, 1'b0, "swr_fetch",   E_FETCH_RDY);
    step(1'b1, 6'h2B, 1'b0, "swr_decode",  E_DECODE);
    step(1'b1, 6'h2B, 1'b0, "swr_addr",    E_MEM_ADDR);
    step(1'b0, 6'h2B, 1'b0, "swr_wr_wait", E_MEM_WR_WT);
    step(1'b0, 6'h2B, 1'b1, "swr_wr_rst",  E_MEM_WR_RST);
    step(1'b1, 6'h3F, 1'b0, "swr_after",   E_FETCH_RDY);

    // Illegal opcode: TRAP held until reset
    step(1'b1, 6'h3F, 1'b0, "trap_decode", E_DECODE);
    for (int i = 0; i < 10; i++) step(1'b1, 6'h3F, 1'b0, "trap_hold", E_TRAP);
    step(1'b1, 6'h3F, 1'b1, "trap_rst",    E_TRAP);
    step(1'b1, 6'h00, 1'b0, "trap_exit",   E_FETCH_RDY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
